// File: rtl/pipelined_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor. The operands are split into STAGES
// segments, and the carry between segments is registered. There is one valid bit
// per pipeline level, and a single global advance enable provides backpressure.
module pipelined_ripple_adder #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             overFlow
);

   localparam int SEG  = WIDTH / STAGES;
   localparam int MSB  = WIDTH - 1;
   localparam int LAST = STAGES - 1;

   // Level j holds a beat after segment j has been added.
   // Slices above segment j are the operand skew.
   // Slices at or below segment j are the sum deskew.
   logic [WIDTH-1:0]  a_q [STAGES];
   logic [WIDTH-1:0]  b_q [STAGES];
   logic [WIDTH-1:0]  s_q [STAGES];
   logic [STAGES-1:0] c_q;
   logic [STAGES-1:0] v_q;
   logic              ovf_q;

   logic [WIDTH-1:0]  a_in   [STAGES];
   logic [WIDTH-1:0]  b_in   [STAGES];
   logic [WIDTH-1:0]  s_in   [STAGES];
   logic [WIDTH-1:0]  s_nx   [STAGES];
   logic [SEG:0]      seg_sum [STAGES];
   logic [STAGES-1:0] c_in;
   logic [STAGES-1:0] c_nx;
   logic [STAGES-1:0] v_in;
   logic              ovf_nx;
   logic              en;

   assign en        = !v_q[LAST] || out_ready;
   assign in_ready  = en && rst_n;
   assign out_valid = v_q[LAST];
   assign S         = s_q[LAST];
   assign Cout      = c_q[LAST];
   assign overFlow  = ovf_q;

   always_comb begin
      a_in[0] = A;
      b_in[0] = Sub ? ~B : B;
      s_in[0] = '0;
      c_in[0] = Sub | Cin;
      v_in[0] = in_valid;
      for (int j = 1; j < STAGES; j++) begin
         a_in[j] = a_q[j-1];
         b_in[j] = b_q[j-1];
         s_in[j] = s_q[j-1];
         c_in[j] = c_q[j-1];
         v_in[j] = v_q[j-1];
      end
      for (int j = 0; j < STAGES; j++) begin
         seg_sum[j] = {1'b0, a_in[j][j*SEG +: SEG]} + {1'b0, b_in[j][j*SEG +: SEG]}
                      + {{SEG{1'b0}}, c_in[j]};
         s_nx[j] = s_in[j];
         s_nx[j][j*SEG +: SEG] = seg_sum[j][SEG-1:0];
         c_nx[j] = seg_sum[j][SEG];
      end
      // The sign bits of A and Beff reach the last segment along the skew path.
      ovf_nx = (a_in[LAST][MSB] == b_in[LAST][MSB])
               && (seg_sum[LAST][SEG-1] != a_in[LAST][MSB]);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int j = 0; j < STAGES; j++) begin
            a_q[j] <= '0;
            b_q[j] <= '0;
            s_q[j] <= '0;
         end
         c_q   <= '0;
         v_q   <= '0;
         ovf_q <= 1'b0;
      end else if (en) begin
         for (int j = 0; j < STAGES; j++) begin
            a_q[j] <= a_in[j];
            b_q[j] <= b_in[j];
            s_q[j] <= s_nx[j];
         end
         c_q   <= c_nx;
         v_q   <= v_in;
         ovf_q <= ovf_nx;
      end
   end

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed and random checks of pipelined_ripple_adder: the default 32/4 build,
// plus 8/1 and 8/8 corner builds.
module tb_pipelined_ripple_adder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   logic        rst_n;
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [31:0] a, b, s;

   logic        iv1, ir1, ov1, co1, of1;
   logic [7:0]  a1, b1, s1;
   logic        iv2, ir2, ov2, co2, of2;
   logic [7:0]  a2, b2, s2;

   pipelined_ripple_adder #(.WIDTH(32), .STAGES(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .A(a), .B(b), .Cin(cin), .Sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .S(s), .Cout(cout), .overFlow(ovf));

   pipelined_ripple_adder #(.WIDTH(8), .STAGES(1)) u_dut_s1 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1),
      .A(a1), .B(b1), .Cin(1'b0), .Sub(1'b0), .out_valid(ov1),
      .out_ready(1'b1), .S(s1), .Cout(co1), .overFlow(of1));

   pipelined_ripple_adder #(.WIDTH(8), .STAGES(8)) u_dut_s8 (
      .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
      .A(a2), .B(b2), .Cin(1'b0), .Sub(1'b0), .out_valid(ov2),
      .out_ready(1'b1), .S(s2), .Cout(co2), .overFlow(of2));

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        cin;
      logic        sub;
      logic [31:0] s;
      logic        c;
      logic        o;
   } vec_t;

   vec_t        dv [6];
   logic [31:0] bp_exp [8];
   logic [33:0] sb [$];

   // Behavioural reference: one WIDTH+1-bit add. Returns {ovf, cout, sum}.
   function automatic logic [33:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                         input logic mcin, input logic msub);
      logic [31:0] be;
      logic [32:0] r;
      logic        o;
      be = msub ? ~mb : mb;
      r  = {1'b0, ma} + {1'b0, be} + {32'b0, (msub ? 1'b1 : mcin)};
      o  = (ma[31] == be[31]) && (r[31] != ma[31]);
      return {o, r};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %0b expected 0", in_ready); end
      checks++; if (s !== 32'h0) begin errors++; $display("FAIL reset_s: got %h expected 00000000", s); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout: got %0b expected 0", cout); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b expected 0", ovf); end
      rst_n = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready: got %0b expected 1", in_ready); end
   endtask

   task automatic test_directed();
      logic early;
      dv[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
      dv[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b1, 1'b0, 32'h00000001, 1'b1, 1'b0};
      dv[2] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
      dv[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
      dv[4] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
      dv[5] = '{32'h00FFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h01000000, 1'b0, 1'b0};
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         a = dv[i].a; b = dv[i].b; cin = dv[i].cin; sub = dv[i].sub; in_valid = 1'b1;
         @(posedge clk); #1;
         in_valid = 1'b0;
         early = 1'b0;
         for (int k = 1; k < 4; k++) begin
            if (out_valid) early = 1'b1;
            @(posedge clk); #1;
         end
         checks++; if (early || out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_latency: early=%0b out_valid=%0b expected early=0 out_valid=1", i, early, out_valid); end
         checks++; if (s !== dv[i].s) begin errors++; $display("FAIL dir%0d_s: got %h expected %h", i, s, dv[i].s); end
         checks++; if (cout !== dv[i].c) begin errors++; $display("FAIL dir%0d_cout: got %0b expected %0b", i, cout, dv[i].c); end
         checks++; if (ovf !== dv[i].o) begin errors++; $display("FAIL dir%0d_ovf: got %0b expected %0b", i, ovf, dv[i].o); end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int sent, got, stall, cyc;
      bp_exp = '{32'h01010101, 32'h12121212, 32'h23232323, 32'h34343434,
                 32'h45454545, 32'h56565656, 32'h67676767, 32'h78787878};
      sent = 0; got = 0; stall = 5; cyc = 0;
      b = 32'h01010101; cin = 1'b0; sub = 1'b0;
      while (got < 8 && cyc < 200) begin
         out_ready = !(got >= 1 && stall > 0);
         if (!out_ready) stall--;
         in_valid = (sent < 8);
         if (sent < 8) a = 32'(sent) * 32'h11111111;
         #1;
         if (!out_ready && out_valid) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_in_ready: got %0b expected 0 (cycle %0d)", in_ready, cyc); end
         end
         if (in_valid && in_ready) sent++;
         if (out_valid && out_ready) begin
            checks++; if (s !== bp_exp[got]) begin errors++; $display("FAIL bp_s%0d: got %h expected %h", got, s, bp_exp[got]); end
            checks++; if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL bp_flags%0d: got cout=%0b ovf=%0b expected 0 0", got, cout, ovf); end
            got++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (got != 8 || stall != 0) begin errors++; $display("FAIL bp_count: got %0d results stall_left=%0d expected 8 and 0", got, stall); end
   endtask

   task automatic test_reset_midflight();
      int seen, seen_k;
      logic [31:0] seen_s;
      out_ready = 1'b1; cin = 1'b0; sub = 1'b0;
      for (int i = 0; i < 3; i++) begin
         a = 32'h10 + 32'(i); b = 32'h20; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0; rst_n = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_in_ready: got %0b expected 0", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_out_valid: got %0b expected 0", out_valid); end
      checks++; if ({s, cout, ovf} !== 34'h0) begin errors++; $display("FAIL mid_rst_outputs: got s=%h cout=%0b ovf=%0b expected all 0", s, cout, ovf); end
      rst_n = 1'b1; a = 32'h1; b = 32'h2; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      seen = 0; seen_k = 0; seen_s = '0;
      for (int k = 1; k <= 8; k++) begin
         if (out_valid) begin
            seen++;
            if (seen == 1) begin seen_k = k; seen_s = s; end
         end
         @(posedge clk); #1;
      end
      checks++; if (seen != 1) begin errors++; $display("FAIL mid_beats: got %0d results expected 1", seen); end
      checks++; if (seen_k != 4) begin errors++; $display("FAIL mid_latency: got %0d cycles expected 4", seen_k); end
      checks++; if (seen_s !== 32'h3) begin errors++; $display("FAIL mid_s: got %h expected 00000003", seen_s); end
   endtask

   task automatic test_corners();
      logic early;
      a1 = 8'h80; b1 = 8'h80; iv1 = 1'b1;
      @(posedge clk); #1;
      iv1 = 1'b0;
      checks++; if (ov1 !== 1'b1) begin errors++; $display("FAIL s1_valid: got %0b expected 1", ov1); end
      checks++; if ({s1, co1, of1} !== {8'h00, 1'b1, 1'b1}) begin errors++; $display("FAIL s1_result: got s=%h cout=%0b ovf=%0b expected 00 1 1", s1, co1, of1); end
      @(posedge clk); #1;
      checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL s1_bubble: got %0b expected 0", ov1); end
      a2 = 8'hFF; b2 = 8'h01; iv2 = 1'b1;
      @(posedge clk); #1;
      iv2 = 1'b0; early = 1'b0;
      for (int k = 1; k < 8; k++) begin
         if (ov2) early = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (early || ov2 !== 1'b1) begin errors++; $display("FAIL s8_latency: early=%0b out_valid=%0b expected early=0 out_valid=1", early, ov2); end
      checks++; if ({s2, co2, of2} !== {8'h00, 1'b1, 1'b0}) begin errors++; $display("FAIL s8_result: got s=%h cout=%0b ovf=%0b expected 00 1 0", s2, co2, of2); end
   endtask

   task automatic test_random();
      int sent, got, cyc;
      logic [33:0] exp;
      sent = 0; got = 0; cyc = 0;
      sb.delete();
      while (got < 1000 && cyc < 20000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         a = $urandom; b = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFF;
         if ($urandom_range(0, 7) == 0) b = 32'h7FFFFFFF;
         cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
         #1;
         checks++; if (in_ready !== (!out_valid || out_ready)) begin errors++; $display("FAIL rnd_in_ready: got %0b expected %0b (cycle %0d)", in_ready, !out_valid || out_ready, cyc); end
         if (in_valid && in_ready) begin
            sb.push_back(model(a, b, cin, sub));
            sent++;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               checks++; errors++; $display("FAIL rnd_extra: unexpected result s=%h at cycle %0d", s, cyc);
            end else begin
               exp = sb.pop_front();
               checks++; if ({ovf, cout, s} !== exp) begin errors++; $display("FAIL rnd_result%0d: got ovf=%0b cout=%0b s=%h expected ovf=%0b cout=%0b s=%h", got, ovf, cout, s, exp[33], exp[32], exp[31:0]); end
            end
            got++;
         end
         @(posedge clk); #1;
         cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++; if (got != 1000) begin errors++; $display("FAIL rnd_count: got %0d results expected 1000", got); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; cin = 1'b0; sub = 1'b0;
      iv1 = 1'b0; a1 = '0; b1 = '0;
      iv2 = 1'b0; a2 = '0; b2 = '0;
      test_reset();
      test_directed();
      test_backpressure();
      test_reset_midflight();
      test_corners();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
